approx_cmp_error_monitor: RTL and testbench

APPROX_CMP_ERROR_MONITOR -- requirements
Module: approx_cmp_error_monitor

---
 rtl/approx_cmp_error_monitor_if.sv | 35 +++
 rtl/approx_cmp_error_monitor.sv | 127 ++++++++++++
 tb/tb_approx_cmp_error_monitor.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_cmp_error_monitor_if.sv
// Sample/control bundle between a stimulus source and the approximate-comparator error monitor.
// master drives samples and start; slave (the monitor) returns handshake, status and counters.
interface approx_cmp_error_monitor_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic [CNT_W-1:0] win_len;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             apx_eq;
   logic             apx_gt;
   logic             apx_lt;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] invalid_cnt;
   logic [CNT_W-1:0] first_err_idx;
   logic             first_err_vld;

   modport master (
      output start, win_len, in_valid, a, b, apx_eq, apx_gt, apx_lt,
      input  in_ready, busy, done, sample_cnt, err_cnt, invalid_cnt,
             first_err_idx, first_err_vld
   );

   modport slave (
      input  start, win_len, in_valid, a, b, apx_eq, apx_gt, apx_lt,
      output in_ready, busy, done, sample_cnt, err_cnt, invalid_cnt,
             first_err_idx, first_err_vld
   );
endinterface

// File: rtl/approx_cmp_error_monitor.sv
// Windowed error monitor for an approximate comparator: compares the reported {eq,gt,lt}
// against an exact unsigned compare in a two-stage pipeline and keeps saturating counts.
module approx_cmp_error_monitor #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic                        clk,
   input logic                        rst_n,
   approx_cmp_error_monitor_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [CNT_W-1:0] r_limit;
   logic [CNT_W-1:0] r_acc;
   logic             r_busy;
   logic             r_done;
   logic             r_s1_vld;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [2:0]       r_s1_apx;
   logic [CNT_W-1:0] r_sample_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [CNT_W-1:0] r_invalid_cnt;
   logic [CNT_W-1:0] r_first_idx;
   logic             r_first_vld;

   logic       w_in_ready;
   logic       w_xfer;
   logic       w_start_ok;
   logic [2:0] w_exact;
   logic       w_mismatch;
   logic       w_invalid;

   assign w_in_ready = (r_state == S_RUN) && (r_acc < r_limit);
   assign w_xfer     = bus.in_valid && w_in_ready;
   assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // Stage 2 decode, ordered {eq, gt, lt} to match the apx triple
   assign w_exact    = {r_s1_a == r_s1_b, r_s1_a > r_s1_b, r_s1_a < r_s1_b};
   assign w_mismatch = (r_s1_apx != w_exact);
   assign w_invalid  = !((r_s1_apx == 3'b100) || (r_s1_apx == 3'b010) ||
                         (r_s1_apx == 3'b001));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_limit       <= '0;
         r_acc         <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_s1_vld      <= 1'b0;
         r_s1_a        <= '0;
         r_s1_b        <= '0;
         r_s1_apx      <= '0;
         r_sample_cnt  <= '0;
         r_err_cnt     <= '0;
         r_invalid_cnt <= '0;
         r_first_idx   <= '0;
         r_first_vld   <= 1'b0;
      end else begin
         r_s1_vld <= w_xfer;
         if (w_xfer) begin
            r_s1_a   <= bus.a;
            r_s1_b   <= bus.b;
            r_s1_apx <= {bus.apx_eq, bus.apx_gt, bus.apx_lt};
            r_acc    <= r_acc + C_ONE;
         end

         if (w_start_ok) begin
            // Start is only honoured in IDLE/DONE, where stage 1 is always empty
            r_limit       <= bus.win_len;
            r_acc         <= '0;
            r_sample_cnt  <= '0;
            r_err_cnt     <= '0;
            r_invalid_cnt <= '0;
            r_first_idx   <= '0;
            r_first_vld   <= 1'b0;
            if (bus.win_len == '0) begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end else begin
               r_state <= S_RUN;
               r_busy  <= 1'b1;
               r_done  <= 1'b0;
            end
         end else begin
            if (r_s1_vld) begin
               if (r_sample_cnt != '1) r_sample_cnt <= r_sample_cnt + C_ONE;
               if (w_mismatch) begin
                  if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + C_ONE;
                  if (!r_first_vld) begin
                     r_first_vld <= 1'b1;
                     r_first_idx <= r_sample_cnt;
                  end
               end
               if (w_invalid && (r_invalid_cnt != '1)) r_invalid_cnt <= r_invalid_cnt + C_ONE;
            end

            case (r_state)
               S_RUN: begin
                  if (w_xfer && ((r_acc + C_ONE) == r_limit)) r_state <= S_DRAIN;
               end
               // The last sample sits in stage 1 during DRAIN and is counted on this edge
               S_DRAIN: begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.sample_cnt    = r_sample_cnt;
   assign bus.err_cnt       = r_err_cnt;
   assign bus.invalid_cnt   = r_invalid_cnt;
   assign bus.first_err_idx = r_first_idx;
   assign bus.first_err_vld = r_first_vld;
endmodule

// File: tb/tb_approx_cmp_error_monitor.sv
// Directed bench for approx_cmp_error_monitor: hand-computed windows plus one random-valid
// window checked against a small behavioural model.
module tb_approx_cmp_error_monitor;
   localparam logic [2:0] EQ = 3'b100;
   localparam logic [2:0] GT = 3'b010;
   localparam logic [2:0] LT = 3'b001;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   approx_cmp_error_monitor_if #(.WIDTH(32), .CNT_W(16)) bus ();

   approx_cmp_error_monitor #(.WIDTH(32), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [15:0] len);
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.win_len = len;
      @(posedge clk); #1;
      bus.start   = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] apx);
      int n;
      n = 0;
      @(posedge clk); #1;
      bus.a = a;
      bus.b = b;
      {bus.apx_eq, bus.apx_gt, bus.apx_lt} = apx;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!bus.done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(bus.done), 32'd1);
   endtask

   task automatic check_counts(input string tag, input int s, input int e, input int inv,
                               input int fv, input int fi);
      check({tag, "_sample"}, 32'(bus.sample_cnt), 32'(s));
      check({tag, "_err"}, 32'(bus.err_cnt), 32'(e));
      check({tag, "_invalid"}, 32'(bus.invalid_cnt), 32'(inv));
      check({tag, "_fvld"}, 32'(bus.first_err_vld), 32'(fv));
      check({tag, "_fidx"}, 32'(bus.first_err_idx), 32'(fi));
   endtask

   initial begin
      int          cyc;
      int          xfers;
      int          m_err;
      int          m_inv;
      int          m_fidx;
      int          m_fvld;
      logic        seen_ready;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rx;
      logic [2:0]  rapx;

      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.win_len = '0;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      {bus.apx_eq, bus.apx_gt, bus.apx_lt} = 3'b000;

      // Reset state
      #13;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check_counts("rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-length window: DONE one cycle after start, in_ready never high
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.win_len = 16'd0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("w0_ready_start", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("w0_done", 32'(bus.done), 32'd1);
      check("w0_busy", 32'(bus.busy), 32'd0);
      check("w0_ready", 32'(bus.in_ready), 32'd0);
      check_counts("w0", 0, 0, 0, 0, 0);
      bus.in_valid = 1'b0;

      // Four correct samples, with a latency check on the first one
      do_start(16'd4);
      @(negedge clk);
      check("w4_busy", 32'(bus.busy), 32'd1);
      check("w4_done_low", 32'(bus.done), 32'd0);
      send(32'h0, 32'h0, EQ);
      @(negedge clk);
      check("w4_lat_n1", 32'(bus.sample_cnt), 32'd0);
      @(negedge clk);
      check("w4_lat_n2", 32'(bus.sample_cnt), 32'd1);
      send(32'h8, 32'h8000, LT);
      send(32'h8000, 32'h8, GT);
      send(32'h8008, 32'h8008, EQ);
      wait_done("w4_done");
      check("w4_busy_end", 32'(bus.busy), 32'd0);
      check_counts("w4", 4, 0, 0, 0, 0);

      // One misreported GT at index 1
      do_start(16'd3);
      send(32'h5, 32'h5, EQ);
      send(32'h8008, 32'h8200, GT);
      send(32'h9, 32'h2, GT);
      wait_done("w3_done");
      check_counts("w3", 3, 1, 0, 1, 1);

      // DONE holds: offered samples are dropped
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a = 32'd1;
      bus.b = 32'd2;
      {bus.apx_eq, bus.apx_gt, bus.apx_lt} = 3'b000;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      check("hold_done", 32'(bus.done), 32'd1);
      check_counts("hold", 3, 1, 0, 1, 1);

      // Non-one-hot triples count as both invalid and errors
      do_start(16'd2);
      send(32'h3, 32'h3, 3'b000);
      send(32'h9, 32'h4, 3'b110);
      wait_done("w2_done");
      check_counts("w2", 2, 2, 2, 1, 0);

      // Start during RUN is ignored
      do_start(16'd2);
      send(32'h1, 32'h1, EQ);
      do_start(16'd9);
      @(negedge clk);
      check("ign_busy", 32'(bus.busy), 32'd1);
      send(32'h7, 32'h1, LT);
      wait_done("ign_done");
      check_counts("ign", 2, 1, 0, 1, 1);

      // Random in_valid over a 100-sample window against a model
      do_start(16'd100);
      xfers = 0; m_err = 0; m_inv = 0; m_fidx = 0; m_fvld = 0; cyc = 0;
      while (xfers < 100 && cyc < 2000) begin
         @(posedge clk); #1;
         ra = 32'($urandom_range(0, 7));
         rb = 32'($urandom_range(0, 7));
         rx = {ra == rb, ra > rb, ra < rb};
         rapx = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : rx;
         bus.a = ra;
         bus.b = rb;
         {bus.apx_eq, bus.apx_gt, bus.apx_lt} = rapx;
         bus.in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) begin
            if (rapx != rx) begin
               m_err++;
               if (m_fvld == 0) begin
                  m_fvld = 1;
                  m_fidx = xfers;
               end
            end
            if (!(rapx == 3'b100 || rapx == 3'b010 || rapx == 3'b001)) m_inv++;
            xfers++;
         end
         cyc++;
      end
      check("rnd_budget", 32'(cyc < 2000), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      seen_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.in_ready) seen_ready = 1'b1;
      end
      bus.in_valid = 1'b0;
      check("rnd_ready_after_limit", 32'(seen_ready), 32'd0);
      wait_done("rnd_done");
      check_counts("rnd", 100, m_err, m_inv, m_fvld, m_fidx);

      // Reset in the middle of a 10-sample window
      do_start(16'd10);
      for (int i = 0; i < 5; i++) send(32'(i), 32'd2, 3'b000);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("mrst_ready", 32'(bus.in_ready), 32'd0);
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check_counts("mrst", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      check("mrst_idle_busy", 32'(bus.busy), 32'd0);
      check("mrst_idle_done", 32'(bus.done), 32'd0);
      check_counts("mrst_idle", 0, 0, 0, 0, 0);
      do_start(16'd2);
      send(32'h4, 32'h4, EQ);
      send(32'h2, 32'h4, LT);
      wait_done("post_done");
      check_counts("post", 2, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
